// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write bypass, load scoreboard and clear sweep
// Decode side reads and marks pending loads; writeback side writes and retires them.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  rd_valid,
  input  logic                  pend_set,
  input  logic [ADDR_WIDTH-1:0] pend_addr,
  output logic                  pend_busy1,
  output logic                  pend_busy2,
  input  logic                  clear_start,
  output logic                  clear_busy
);
  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   pend;
  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] counter;
  logic                  wr_ok, pend_ok, sweep_start;
  logic [DATA_WIDTH-1:0] rd_next1, rd_next2;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Only traffic that actually lands in the array may bypass or touch the scoreboard.
  assign wr_ok       = wr_en && (state == IDLE) && in_range(wr_addr) && !is_zero_reg(wr_addr);
  assign pend_ok     = pend_set && (state == IDLE) && in_range(pend_addr) && !is_zero_reg(pend_addr);
  assign sweep_start = clear_start && (state == IDLE);

  assign pend_busy1 = in_range(rd_addr1) ? pend[rd_addr1] : 1'b0;
  assign pend_busy2 = in_range(rd_addr2) ? pend[rd_addr2] : 1'b0;

  always_comb begin
    rd_next1 = '0;
    if ((BYPASS != 0) && wr_ok && (rd_addr1 == wr_addr))
      rd_next1 = wr_data;
    else if (in_range(rd_addr1) && !is_zero_reg(rd_addr1))
      rd_next1 = mem[rd_addr1];
  end

  always_comb begin
    rd_next2 = '0;
    if ((BYPASS != 0) && wr_ok && (rd_addr2 == wr_addr))
      rd_next2 = wr_data;
    else if (in_range(rd_addr2) && !is_zero_reg(rd_addr2))
      rd_next2 = mem[rd_addr2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (state == SWEEP) begin
      mem[counter] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A new load marked in the same cycle as a writeback wins over the retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else if (sweep_start) begin
      pend <= '0;
    end else begin
      if (wr_ok)   pend[wr_addr]   <= 1'b0;
      if (pend_ok) pend[pend_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data1 <= rd_next1;
        rd_data2 <= rd_next2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state <= state_next;
      if (state == SWEEP && counter != LAST_IDX)
        counter <= counter + ADDR_WIDTH'(1);
      else
        counter <= '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_start) state_next = SWEEP;
      SWEEP:   if (counter == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state == SWEEP);
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wr_en, rd_en, pend_set, clear_start;
  logic [4:0]  wr_addr, rd_addr1, rd_addr2, pend_addr;
  logic [31:0] wr_data;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_rv, a_pb1, a_pb2, a_cb, b_rv, b_pb1, b_pb2, b_cb;

  regfile_scoreboard #(.NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(a_rd1),
    .rd_data2(a_rd2), .rd_valid(a_rv), .pend_set(pend_set), .pend_addr(pend_addr),
    .pend_busy1(a_pb1), .pend_busy2(a_pb2), .clear_start(clear_start), .clear_busy(a_cb));

  regfile_scoreboard #(.NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(b_rd1),
    .rd_data2(b_rd2), .rd_valid(b_rv), .pend_set(pend_set), .pend_addr(pend_addr),
    .pend_busy1(b_pb1), .pend_busy2(b_pb2), .clear_start(clear_start), .clear_busy(b_cb));

  int checks = 0;
  int errors = 0;

  // Reference model: instance 0 = dut_a, instance 1 = dut_b.
  int          nr [2] = '{32, 24};
  bit          zr [2] = '{1'b1, 1'b0};
  bit          bp [2] = '{1'b1, 1'b0};
  logic [31:0] mm [2][32];
  bit          pm [2][32];
  logic [31:0] m_rd1 [2];
  logic [31:0] m_rd2 [2];
  bit          m_rv [2];
  int          sweep_left [2];

  function automatic logic [31:0] mval(int k, logic [4:0] a);
    if (int'(a) >= nr[k] || (zr[k] && a == 5'd0)) return 32'd0;
    return mm[k][a];
  endfunction

  function automatic bit mpend(int k, logic [4:0] a);
    if (int'(a) >= nr[k]) return 1'b0;
    return pm[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        mm[k][i] = 32'd0;
        pm[k][i] = 1'b0;
      end
      m_rd1[k] = 32'd0;
      m_rd2[k] = 32'd0;
      m_rv[k] = 1'b0;
      sweep_left[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit idle, wok, pok;
    for (int k = 0; k < 2; k++) begin
      idle = (sweep_left[k] == 0);
      wok  = wr_en && idle && int'(wr_addr) < nr[k] && !(zr[k] && wr_addr == 5'd0);
      pok  = pend_set && idle && int'(pend_addr) < nr[k] && !(zr[k] && pend_addr == 5'd0);
      if (rd_en) begin
        m_rd1[k] = (bp[k] && wok && rd_addr1 == wr_addr) ? wr_data : mval(k, rd_addr1);
        m_rd2[k] = (bp[k] && wok && rd_addr2 == wr_addr) ? wr_data : mval(k, rd_addr2);
      end
      m_rv[k] = rd_en;
      if (!idle) begin
        mm[k][nr[k] - sweep_left[k]] = 32'd0;
        sweep_left[k]--;
      end else begin
        if (wok) begin
          mm[k][wr_addr] = wr_data;
          pm[k][wr_addr] = 1'b0;
        end
        if (pok) pm[k][pend_addr] = 1'b1;
        if (clear_start) begin
          for (int i = 0; i < 32; i++) pm[k][i] = 1'b0;
          sweep_left[k] = nr[k];
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a.rd_data1", a_rd1, m_rd1[0]);
    chk("a.rd_data2", a_rd2, m_rd2[0]);
    chk("a.rd_valid", {31'd0, a_rv}, {31'd0, m_rv[0]});
    chk("a.pend_busy1", {31'd0, a_pb1}, {31'd0, mpend(0, rd_addr1)});
    chk("a.pend_busy2", {31'd0, a_pb2}, {31'd0, mpend(0, rd_addr2)});
    chk("a.clear_busy", {31'd0, a_cb}, {31'd0, sweep_left[0] != 0});
    chk("b.rd_data1", b_rd1, m_rd1[1]);
    chk("b.rd_data2", b_rd2, m_rd2[1]);
    chk("b.rd_valid", {31'd0, b_rv}, {31'd0, m_rv[1]});
    chk("b.pend_busy1", {31'd0, b_pb1}, {31'd0, mpend(1, rd_addr1)});
    chk("b.pend_busy2", {31'd0, b_pb2}, {31'd0, mpend(1, rd_addr2)});
    chk("b.clear_busy", {31'd0, b_cb}, {31'd0, sweep_left[1] != 0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr1 = 0; rd_addr2 = 0;
    pend_set = 0; pend_addr = 0; clear_start = 0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra1, ra2;
    logic        ps;
    logic [4:0]  pa;
    logic [31:0] a_rd1, a_rd2;
    logic        a_rv, a_pb1;
    logic [31:0] b_rd1, b_rd2;
    logic        b_pb1;
  } vec_t;

  vec_t vt [10];
  int   cnt_a, cnt_b;

  initial begin
    vt[0] = '{1'b1, 5'd0,  32'h7,    1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,  32'h0,    1'b0, 1'b0, 32'h0,  32'h0,    1'b0};
    vt[1] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,  32'h0,    1'b1, 1'b0, 32'h7,  32'h7,    1'b0};
    vt[2] = '{1'b1, 5'd5,  32'hA,    1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,  32'h0,    1'b0, 1'b0, 32'h7,  32'h7,    1'b0};
    vt[3] = '{1'b1, 5'd3,  32'h1234, 1'b1, 5'd5,  5'd3, 1'b0, 5'd0,  32'hA,  32'h1234, 1'b1, 1'b0, 32'hA,  32'h0,    1'b0};
    vt[4] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd7,  5'd3, 1'b1, 5'd7,  32'hA,  32'h1234, 1'b0, 1'b1, 32'hA,  32'h0,    1'b1};
    vt[5] = '{1'b1, 5'd7,  32'h55,   1'b0, 5'd7,  5'd3, 1'b0, 5'd0,  32'hA,  32'h1234, 1'b0, 1'b0, 32'hA,  32'h0,    1'b0};
    vt[6] = '{1'b1, 5'd7,  32'h66,   1'b0, 5'd7,  5'd3, 1'b1, 5'd7,  32'hA,  32'h1234, 1'b0, 1'b1, 32'hA,  32'h0,    1'b1};
    vt[7] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  5'd3, 1'b0, 5'd0,  32'h66, 32'h1234, 1'b1, 1'b1, 32'h66, 32'h1234, 1'b1};
    vt[8] = '{1'b1, 5'd30, 32'h99,   1'b0, 5'd30, 5'd3, 1'b1, 5'd30, 32'h66, 32'h1234, 1'b0, 1'b1, 32'h66, 32'h1234, 1'b0};
    vt[9] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd30, 5'd0, 1'b0, 5'd0,  32'h99, 32'h0,    1'b1, 1'b1, 32'h0,  32'h7,    1'b0};

    idle_inputs();
    reset = 1'b1;
    #7 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();

    for (int i = 0; i < 10; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_en = vt[i].re; rd_addr1 = vt[i].ra1; rd_addr2 = vt[i].ra2;
      pend_set = vt[i].ps; pend_addr = vt[i].pa; clear_start = 1'b0;
      step();
      chk($sformatf("vec%0d.a_rd1", i), a_rd1, vt[i].a_rd1);
      chk($sformatf("vec%0d.a_rd2", i), a_rd2, vt[i].a_rd2);
      chk($sformatf("vec%0d.a_rv", i), {31'd0, a_rv}, {31'd0, vt[i].a_rv});
      chk($sformatf("vec%0d.a_pb1", i), {31'd0, a_pb1}, {31'd0, vt[i].a_pb1});
      chk($sformatf("vec%0d.b_rd1", i), b_rd1, vt[i].b_rd1);
      chk($sformatf("vec%0d.b_rd2", i), b_rd2, vt[i].b_rd2);
      chk($sformatf("vec%0d.b_pb1", i), {31'd0, b_pb1}, {31'd0, vt[i].b_pb1});
    end

    // Fill, sweep with writes and a second clear_start in flight, then read back.
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000 + 32'(i);
      step();
    end
    idle_inputs();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    cnt_a = int'(a_cb);
    cnt_b = int'(b_cb);
    for (int n = 0; n < 60 && (a_cb || b_cb); n++) begin
      wr_en = b_cb; wr_addr = 5'($urandom_range(0, 31)); wr_data = $urandom;
      pend_set = b_cb; pend_addr = 5'($urandom_range(1, 20));
      clear_start = (n == 10);
      step();
      cnt_a += int'(a_cb);
      cnt_b += int'(b_cb);
    end
    chk("sweep_len_a", 32'(cnt_a), 32'd32);
    chk("sweep_len_b", 32'(cnt_b), 32'd24);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1; rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      step();
      chk("post_clear_a_rd1", a_rd1, 32'd0);
      chk("post_clear_b_rd2", b_rd2, 32'd0);
    end

    // Asynchronous reset in the middle of a sweep.
    idle_inputs();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_sweep_a_cb", {31'd0, a_cb}, 32'd0);
    chk("async_sweep_b_cb", {31'd0, b_cb}, 32'd0);
    #1 reset = 1'b0;
    step();

    // Asynchronous reset with pending loads and live read data.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    step();
    wr_en = 1'b0; pend_set = 1'b1; pend_addr = 5'd9; rd_en = 1'b1; rd_addr1 = 5'd4; rd_addr2 = 5'd4;
    step();
    pend_set = 1'b0; rd_en = 1'b0; rd_addr1 = 5'd9;
    #1;
    chk("pre_reset_pend", {31'd0, a_pb1}, 32'd1);
    chk("pre_reset_rd", a_rd1, 32'h44);
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("async_a_rd1", a_rd1, 32'd0);
    chk("async_b_rd2", b_rd2, 32'd0);
    chk("async_a_rv", {31'd0, a_rv}, 32'd0);
    chk("async_a_pb1", {31'd0, a_pb1}, 32'd0);
    chk("async_b_pb1", {31'd0, b_pb1}, 32'd0);
    #1 reset = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom); wr_data = $urandom;
      rd_en = 1'($urandom_range(0, 1)); rd_addr1 = 5'($urandom); rd_addr2 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr2 = wr_addr;
      pend_set = 1'($urandom_range(0, 1)); pend_addr = 5'($urandom);
      clear_start = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
